reg_scoreboard: RTL

In-order pending-write scoreboard for the GPU/DSP register file in Tom. It records the 6-bit destination register number of every issued instruction whose result is still in flight and retires entries in order as write-backs complete. It flags read-after-write and write-after-write hazards against the source and destination operands of the instruction being issued. It feeds the issue-stall logic and drives the write-back register address.

---
 rtl/reg_scoreboard.sv | 101 ++++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// In-order pending-write scoreboard: tracks in-flight destination registers,
// flags RAW/WAW hazards at issue and retires entries in order on write-back.
// Optional feature macro: REG_SCOREBOARD_FWD_EN (head excluded from matching while retiring).
module reg_scoreboard #(
    parameter int DEPTH = 4,
    parameter int AW    = 6
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_dst,
    output logic          iss_ready,
    input  logic [AW-1:0] src_a,
    input  logic [AW-1:0] src_b,
    input  logic          src_a_use,
    input  logic          src_b_use,
    output logic          hazard,
    input  logic          wb_valid,
    output logic [AW-1:0] wb_dst,
    output logic          wb_err,
    output logic [3:0]    count,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]    ent_q [DEPTH];
    logic [DEPTH-1:0] live_q;
    logic [PW-1:0]    head_q, tail_q;
    logic [3:0]       count_q, count_d;
    logic             wb_err_q;

    logic             empty_w, push, pop;
    logic [DEPTH-1:0] excl, match;

    assign empty_w   = (count_q == 4'd0);
    assign pop       = wb_valid & ~empty_w;
    // A retiring head frees its slot in the same cycle, so a full FIFO can still accept.
    assign iss_ready = (count_q < 4'(DEPTH)) | pop;
    assign push      = iss_valid & iss_ready & ~hazard;

`ifdef REG_SCOREBOARD_FWD_EN
    // Write-back data is forwarded, so the retiring head no longer blocks anyone.
    always_comb begin
        excl = '0;
        if (pop) excl[head_q] = 1'b1;
    end
`else
    assign excl = '0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = live_q[gi] & ~excl[gi] &
                               ((src_a_use & (ent_q[gi] == src_a)) |
                                (src_b_use & (ent_q[gi] == src_b)) |
                                (iss_valid & (ent_q[gi] == iss_dst)));
        end
    endgenerate

    assign hazard = |match;
    assign wb_dst = ent_q[head_q];
    assign wb_err = wb_err_q;
    assign count  = count_q;
    assign empty  = empty_w;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            live_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            wb_err_q <= 1'b0;
        end else begin
            wb_err_q <= wb_valid & empty_w;
            // Pop before push: when full, head and tail share a slot and the push must win.
            if (pop) begin
                live_q[head_q] <= 1'b0;
                head_q         <= head_q + PW'(1);
            end
            if (push) begin
                ent_q[tail_q]  <= iss_dst;
                live_q[tail_q] <= 1'b1;
                tail_q         <= tail_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule
